hilo_muldiv_unit: RTL
=====================

Name: hilo_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit that owns the architectural Hi/Lo register pair. It supports MULT, MULTU, MADD, MSUB, DIV, DIVU, MTHI and MTLO. It sits beside the single-cycle 32-bit ALU in EX and replaces the ALU's combinational 64-bit multiply paths. The pipeline stalls on Busy and reads Hi/Lo directly for MFHI/MFLO.

Parameters:
WIDTH, 32, operand and Hi/Lo register width in bits (even, >=8)
CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH

Ports:
Clk  input  1  system clock, all state updates on rising edge
Reset  input  1  synchronous, active-low reset
Start  input  1  request pulse; accepted only when Busy=0
Op  input  3  0 MULT, 1 MULTU, 2 MADD, 3 MSUB, 4 DIV, 5 DIVU, 6 MTHI, 7 MTLO
A  input  WIDTH  operand A (rs / dividend / MTHI-MTLO source)
B  input  WIDTH  operand B (rt / divisor)
Busy  output  1  iterative operation in progress
Done  output  1  one-cycle pulse: Hi/Lo updated on the previous edge
DivByZero  output  1  one-cycle pulse coincident with Done for DIV/DIVU with B=0
Hi  output  WIDTH  Hi register
Lo  output  WIDTH  Lo register

Behaviour:
- Clock is Clk. Reset is synchronous and active-low: Reset=0 at a rising edge forces state IDLE, Busy=0, Done=0, DivByZero=0, Hi=0, Lo=0, and counter=0. This applies mid-operation as well: the in-flight operation is discarded and no Done is produced.
- FSM states: IDLE, RUN, FIX.
- IDLE + Start + Op in 0..5:
  - Latch Op, A and B.
  - Convert signed operands to magnitudes and record the result sign. Ops 0, 2, 3 and 4 are signed; ops 1 and 5 are unsigned.
  - Counter=0. Go to RUN. Busy=1 from this edge.
- RUN: one shift-add (multiply) or restoring shift-subtract (divide) iteration per cycle. Go to FIX when counter reaches WIDTH-1.
- FIX: apply sign correction and write the result to Hi/Lo. Busy=0 and Done=1 from this edge; go to IDLE.
- Latency: the accept edge is edge 0. Hi/Lo are written at edge WIDTH+1, and Done is high for the cycle after that edge.
- IDLE + Start + Op 6 or 7: at the accept edge, Hi<=A (MTHI) or Lo<=A (MTLO). Busy is never asserted; Done=1 for the next cycle.
- Start while Busy=1 is ignored entirely, with no queueing. Start in the Done cycle is legal and accepted, because Busy=0.
- Arithmetic (all results mod 2^(2*WIDTH)):
  - MULT/MULTU: {Hi,Lo} = A*B.
  - MADD: {Hi,Lo} = {Hi,Lo} + signed(A*B).
  - MSUB: {Hi,Lo} = {Hi,Lo} - signed(A*B).
  - For MADD/MSUB, the {Hi,Lo} value used is the value at the FIX edge.
- DIV/DIVU: Lo = quotient truncated toward zero; Hi = remainder, which carries the sign of the dividend.
- DIV with A = most-negative and B = -1: Lo = most-negative (wraps), Hi = 0.
- B=0 for DIV/DIVU: runs the full latency. Hi and Lo are left unchanged; Done=1 and DivByZero=1 in the same cycle.
- DivByZero is 0 for every other completion.
- A and B may change after the accept edge without affecting the result.

Test Plan:
1. Reset=0 for 2 edges, then Reset=1 -> Hi=0, Lo=0, Busy=0, Done=0, DivByZero=0.
2. MULT A=FFFFFFFD (-3), B=00000007 -> Busy for 33 cycles; Hi=FFFFFFFF, Lo=FFFFFFEB; Done for exactly one cycle.
3. MULTU A=FFFFFFFF, B=FFFFFFFF -> Hi=FFFFFFFE, Lo=00000001.
4. MTHI A=0, then MTLO A=0000000A, then MADD A=4, B=5 -> Lo=0000001E, Hi=0. Follow with MSUB A=2, B=0000000F -> Lo=00000000, Hi=0.
5. DIV A=FFFFFFF9 (-7), B=2 -> Lo=FFFFFFFD, Hi=FFFFFFFF. DIVU with the same operands -> Lo=7FFFFFFC, Hi=00000001. DIV A=80000000, B=FFFFFFFF -> Lo=80000000, Hi=0.
6. DIV A=5, B=0 with prior Hi=1234, Lo=5678 -> Hi and Lo unchanged; DivByZero=1 together with Done.
7. Stress: a second Start 5 cycles into a MULT is ignored. A Start in the Done cycle is accepted. Reset=0 at cycle 10 of a DIV aborts it: Hi=Lo=0, no Done.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// hilo_muldiv_unit
//   Iterative multiply/divide unit that owns the architectural Hi/Lo pair.
//   Runs MULT/MULTU/MADD/MSUB with one shift-add step per cycle and
//   DIV/DIVU with one restoring shift-subtract step per cycle; MTHI/MTLO
//   write Hi/Lo directly at the accept edge.
//
//   state | meaning
//   IDLE  | waiting for Start; MTHI/MTLO complete here
//   RUN   | one iteration per cycle, WIDTH iterations total
//   FIX   | sign correction, Hi/Lo write-back, Done pulse follows
//
// Ports
//   Clk        system clock, rising edge
//   Reset      synchronous active-low reset
//   Start      request pulse, honoured only while Busy=0
//   Op         0 MULT 1 MULTU 2 MADD 3 MSUB 4 DIV 5 DIVU 6 MTHI 7 MTLO
//   A, B       operands (A also the MTHI/MTLO source)
//   Busy       iterative operation in progress
//   Done       one-cycle pulse after Hi/Lo were updated
//   DivByZero  one-cycle pulse with Done for a divide by zero
//   Hi, Lo     architectural Hi/Lo registers
module hilo_muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             Busy,
    output logic             Done,
    output logic             DivByZero,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo
);

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MADD  = 3'd2;
    localparam logic [2:0] OP_MSUB  = 3'd3;
    localparam logic [2:0] OP_DIV   = 3'd4;
    localparam logic [2:0] OP_DIVU  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state, next_state;

    logic               accept_run;
    logic               accept_move;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   mcand;      // multiplicand, or divisor magnitude
    logic [2*WIDTH-1:0] acc;        // {partial product, multiplier} or {remainder, quotient}
    logic               neg_q;      // product / quotient sign
    logic               neg_r;      // remainder sign (dividend sign)
    logic               b_zero;
    logic [CNT_W-1:0]   counter;
    logic               last_iter;

    logic               in_signed;
    logic               in_div;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    logic               is_div;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] acc_next;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;
    logic [2*WIDTH-1:0] fix_result;

    assign Busy      = (state != IDLE);
    assign last_iter = (counter == CNT_W'(WIDTH - 1));

    // Operand conditioning at the accept edge
    assign in_signed = (Op == OP_MULT) || (Op == OP_MADD) || (Op == OP_MSUB) || (Op == OP_DIV);
    assign in_div    = (Op == OP_DIV) || (Op == OP_DIVU);
    assign a_neg     = in_signed & A[WIDTH-1];
    assign b_neg     = in_signed & B[WIDTH-1];
    assign a_mag     = a_neg ? -A : A;
    assign b_mag     = b_neg ? -B : B;

    assign is_div    = (op_q == OP_DIV) || (op_q == OP_DIVU);

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        accept_run  = 1'b0;
        accept_move = 1'b0;
        case (state)
            IDLE: begin
                if (Start) begin
                    if ((Op == OP_MTHI) || (Op == OP_MTLO)) begin
                        accept_move = 1'b1;
                    end else begin
                        accept_run = 1'b1;
                        next_state = RUN;
                    end
                end
            end
            RUN: begin
                if (last_iter) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // One iteration step. The divide shifts {rem, quot} left and keeps the
    // subtraction only when it does not borrow (restoring division).
    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? mcand : {WIDTH{1'b0}})};
        div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, mcand};
        if (is_div) begin
            if (div_trial[WIDTH]) begin
                acc_next = {acc[2*WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {mul_sum, acc[WIDTH-1:1]};
        end
    end

    // Sign correction and accumulate for the FIX edge
    always_comb begin
        prod = neg_q ? -acc : acc;
        quot = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        case (op_q)
            OP_MADD:          fix_result = {Hi, Lo} + prod;
            OP_MSUB:          fix_result = {Hi, Lo} - prod;
            OP_DIV, OP_DIVU:  fix_result = {rem, quot};
            default:          fix_result = prod;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            Hi        <= '0;
            Lo        <= '0;
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            op_q      <= OP_MULT;
            mcand     <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            b_zero    <= 1'b0;
            counter   <= '0;
        end else begin
            Done      <= 1'b0;
            DivByZero <= 1'b0;
            if (accept_move) begin
                if (Op == OP_MTHI) begin
                    Hi <= A;
                end else begin
                    Lo <= A;
                end
                Done <= 1'b1;
            end
            if (accept_run) begin
                op_q    <= Op;
                mcand   <= in_div ? b_mag : a_mag;
                acc     <= in_div ? {{WIDTH{1'b0}}, a_mag} : {{WIDTH{1'b0}}, b_mag};
                neg_q   <= a_neg ^ b_neg;
                neg_r   <= a_neg;
                b_zero  <= (B == '0);
                counter <= '0;
            end
            if (state == RUN) begin
                acc     <= acc_next;
                counter <= counter + CNT_W'(1);
            end
            if (state == FIX) begin
                Done <= 1'b1;
                if (is_div && b_zero) begin
                    DivByZero <= 1'b1;
                end else begin
                    {Hi, Lo} <= fix_result;
                end
            end
        end
    end

endmodule
